// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline boundary registers: control-bit
// layout and the EX/MEM payload packing at the default core widths.
package pipe_pkg;

  localparam int CTRL_W        = 4;
  localparam int CTRL_REGWRITE = 3;
  localparam int CTRL_MEMTOREG = 2;
  localparam int CTRL_MEMREAD  = 1;
  localparam int CTRL_MEMWRITE = 0;

  localparam int EXMEM_DATA_W  = 32;
  localparam int EXMEM_REG_W   = 5;

  // EX/MEM payload at default widths (73 bits), MSB first.
  typedef struct packed {
    logic [CTRL_W-1:0]       ctrl;
    logic [EXMEM_REG_W-1:0]  writereg;
    logic [EXMEM_DATA_W-1:0] alu_input2;
    logic [EXMEM_DATA_W-1:0] alu_result;
  } ex_mem_payload_t;

  // Payload width for a non-default datapath/register-file configuration.
  function automatic int exmem_payload_w(input int data_w, input int reg_w);
    return CTRL_W + reg_w + 2 * data_w;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer with flush. The main slot drives the output;
// the skid slot catches one transfer while the consumer stalls, so the
// upstream ready can come straight from a flop.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid, skid_valid;
  logic [W-1:0] main_data, skid_data;

  logic acc, drn;
  logic main_valid_d, skid_valid_d;
  logic main_load, main_from_skid, skid_load;

  // Ready is simply "skid slot empty", which is itself a flop.
  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign out_data  = main_data;

  assign acc = in_valid & in_ready & ~flush;
  assign drn = main_valid & out_ready;

  // Next-state and load-enable decode for both slots.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no branch can leave one unassigned and infer a latch.
    main_valid_d   = main_valid;
    skid_valid_d   = skid_valid;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (flush) begin
      // A head being drained this cycle still completes its handshake;
      // only new loads are suppressed.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid || drn) begin
      if (skid_valid) begin
        // Skid entry is older than anything arriving now: promote it first.
        main_load      = 1'b1;
        main_from_skid = 1'b1;
        main_valid_d   = 1'b1;
        skid_load      = acc;
        skid_valid_d   = acc;
      end else if (acc) begin
        main_load    = 1'b1;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (acc) begin
      skid_load    = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  // Valid bits.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    if (reset) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= main_valid_d;
      skid_valid <= skid_valid_d;
    end
  end

  // Payload slots: load only on an explicit load event, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: payload flops are reset as well so the outputs read all-zero straight out of reset.
    if (reset) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (main_load) main_data <= main_from_skid ? skid_data : in_data;
      if (skid_load) skid_data <= in_data;
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline boundary register. Packs the EX results into one payload,
// buffers it in a 2-entry skid buffer so a MEM stall never drops work, and
// gates the side-effecting control bits when no valid entry is presented.
module ex_mem_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              EXMEM_valid_in,
  output logic              EXMEM_ready_out,
  input  logic [DATA_W-1:0] EXMEM_ALUresult_in,
  input  logic [DATA_W-1:0] EXMEM_ALUinput2_in,
  input  logic [REG_W-1:0]  EXMEM_writereg_in,
  input  logic [CTRL_W-1:0] EXMEM_ctrl_in,
  output logic              EXMEM_valid_out,
  input  logic              EXMEM_ready_in,
  output logic [DATA_W-1:0] EXMEM_ALUresult_out,
  output logic [DATA_W-1:0] EXMEM_ALUinput2_out,
  output logic [REG_W-1:0]  EXMEM_writereg_out,
  output logic [CTRL_W-1:0] EXMEM_ctrl_out
);

  localparam int PAYLOAD_W = exmem_payload_w(DATA_W, REG_W);

  // Same field order as pipe_pkg::ex_mem_payload_t, sized by this instance.
  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]  writereg;
    logic [DATA_W-1:0] alu_input2;
    logic [DATA_W-1:0] alu_result;
  } payload_t;

  payload_t in_pl, head_pl;
  logic     head_valid;

  assign in_pl = '{ctrl:       EXMEM_ctrl_in,
                   writereg:   EXMEM_writereg_in,
                   alu_input2: EXMEM_ALUinput2_in,
                   alu_result: EXMEM_ALUresult_in};

  pipe_skid_buf #(.W(PAYLOAD_W)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (EXMEM_valid_in),
    .in_ready  (EXMEM_ready_out),
    .in_data   (in_pl),
    .out_valid (head_valid),
    .out_ready (EXMEM_ready_in),
    .out_data  (head_pl)
  );

  assign EXMEM_valid_out     = head_valid;
  assign EXMEM_ALUresult_out = head_pl.alu_result;
  assign EXMEM_ALUinput2_out = head_pl.alu_input2;
  assign EXMEM_writereg_out  = head_pl.writereg;

  // Stale or flushed data must never write the register file or memory.
  always_comb begin
    EXMEM_ctrl_out = head_pl.ctrl;
    if (!head_valid) begin
      EXMEM_ctrl_out[CTRL_REGWRITE] = 1'b0;
      EXMEM_ctrl_out[CTRL_MEMREAD]  = 1'b0;
      EXMEM_ctrl_out[CTRL_MEMWRITE] = 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg. The reference model is a bounded
// FIFO of depth 2: accepted entries queue up in order, the head is consumed
// on valid&ready, flush empties it, and ready is "fewer than two held".
module tb_ex_mem_skid_reg;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [4:0]  writereg;
    logic [31:0] alu_input2;
    logic [31:0] alu_result;
  } item_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        valid_in;
  logic        ready_out;
  logic [31:0] alu_in, op2_in;
  logic [4:0]  wreg_in;
  logic [3:0]  ctrl_in;
  logic        valid_out;
  logic        ready_in;
  logic [31:0] alu_out, op2_out;
  logic [4:0]  wreg_out;
  logic [3:0]  ctrl_out;

  int    n_checks = 0;
  int    n_pass   = 0;
  item_t sb[$];
  logic  model_ready;

  always #5 clk = ~clk;

  ex_mem_skid_reg dut (
    .clk                 (clk),
    .reset               (reset),
    .flush               (flush),
    .EXMEM_valid_in      (valid_in),
    .EXMEM_ready_out     (ready_out),
    .EXMEM_ALUresult_in  (alu_in),
    .EXMEM_ALUinput2_in  (op2_in),
    .EXMEM_writereg_in   (wreg_in),
    .EXMEM_ctrl_in       (ctrl_in),
    .EXMEM_valid_out     (valid_out),
    .EXMEM_ready_in      (ready_in),
    .EXMEM_ALUresult_out (alu_out),
    .EXMEM_ALUinput2_out (op2_out),
    .EXMEM_writereg_out  (wreg_out),
    .EXMEM_ctrl_out      (ctrl_out)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Issue one cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic cyc(input logic v, input logic [31:0] alu, input logic f, input logic r);
    valid_in = v;
    alu_in   = alu;
    op2_in   = $urandom;
    wreg_in  = 5'($urandom_range(0, 31));
    ctrl_in  = 4'($urandom_range(0, 15));
    flush    = f;
    ready_in = r;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare DUT against the model state at mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      int    n;
      item_t exp_it;
      n = sb.size();
      model_ready = (n < 2);
      check("valid_out", valid_out, n > 0);
      check("ready_out", ready_out, n < 2);
      if (!valid_out) check("ctrl_gated", ctrl_out & 4'b1011, 4'b0000);
      if (valid_out && ready_in && n > 0) begin
        exp_it = sb.pop_front();
        check("head_payload", {ctrl_out, wreg_out, op2_out, alu_out}, exp_it);
      end
    end
  end

  // Issue side: record what the model says was accepted (after the monitor pops).
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      if (flush) sb.delete();
      else if (valid_in && model_ready)
        sb.push_back('{ctrl: ctrl_in, writereg: wreg_in, alu_input2: op2_in, alu_result: alu_in});
    end
  end

  initial begin
    reset = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
    alu_in = '0; op2_in = '0; wreg_in = '0; ctrl_in = '0;
    #2;
    check("rst_valid", valid_out, 1'b0);
    check("rst_ready", ready_out, 1'b1);
    check("rst_data", {ctrl_out, wreg_out, op2_out, alu_out}, '0);
    #10 reset = 1'b0;
    @(posedge clk); #1;

    // Back-to-back stream with MEM always ready.
    cyc(1, 32'h10, 0, 1);
    cyc(1, 32'h20, 0, 1);
    cyc(1, 32'h30, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Stall capture, input refused while full, in-order release.
    cyc(1, 32'hA, 0, 0);
    cyc(1, 32'hB, 0, 0);
    cyc(1, 32'hC, 0, 0);
    cyc(1, 32'hC, 0, 0);
    cyc(1, 32'hC, 0, 1);
    cyc(1, 32'hC, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Flush mid-stall with a new offer that must never appear.
    cyc(1, 32'h1, 0, 0);
    cyc(1, 32'h2, 0, 0);
    cyc(1, 32'h3, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Flush while the head is being drained.
    cyc(1, 32'h7, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 1);

    // Asynchronous reset between edges with both slots full.
    cyc(1, 32'h4, 0, 0);
    cyc(1, 32'h5, 0, 0);
    cyc(0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", valid_out, 1'b0);
    check("arst_ready", ready_out, 1'b1);
    check("arst_data", {ctrl_out, wreg_out, op2_out, alu_out}, '0);
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    cyc(1, 32'h55, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);

    // Randomised traffic with occasional flushes.
    for (int i = 0; i < 600; i++)
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 19) == 0),
          1'($urandom_range(0, 2) != 0));

    // Drain and confirm nothing was left behind.
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);
    check("sb_empty", 128'(sb.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- EX/MEM pipeline boundary register for the 5-stage MIPS pipeline.
- Captures the EX-stage ALU result, the forwarded store data from the EX operand-2 forwarding mux, the destination register and the MEM/WB control bits.
- Presents them to the MEM stage and back to the EX forwarding muxes.
- Uses a 2-entry skid buffer with valid/ready handshake, so a MEM-side stall (multi-cycle data memory) never drops an EX result, and a flush input squashes wrong-path work.

Parameters:
- DATA_W, 32, width of ALU result and store data.
- REG_W, 5, register-file index width.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  squash all held and incoming entries (branch/exception)
- EXMEM_valid_in  input  1  EX offers an instruction this cycle
- EXMEM_ready_out  output  1  register can accept (registered, no comb path from MEM)
- EXMEM_ALUresult_in  input  DATA_W  ALU result from EX
- EXMEM_ALUinput2_in  input  DATA_W  forwarded operand 2 (store data)
- EXMEM_writereg_in  input  REG_W  destination register
- EXMEM_ctrl_in  input  4  {RegWrite, MemtoReg, MemRead, MemWrite}
- EXMEM_valid_out  output  1  MEM-side entry valid
- EXMEM_ready_in  input  1  MEM stage accepts this cycle
- EXMEM_ALUresult_out  output  DATA_W  head ALU result (also to forwarding mux)
- EXMEM_ALUinput2_out  output  DATA_W  head store data
- EXMEM_writereg_out  output  REG_W  head destination register
- EXMEM_ctrl_out  output  4  head control bits; RegWrite/MemRead/MemWrite forced 0 when EXMEM_valid_out=0

Behaviour:
- Storage: main slot (drives outputs) and skid slot, each with its own valid bit.
- Reset (async, immediate): both valids 0, all data/ctrl regs 0, EXMEM_ready_out=1, all outputs 0.
- EXMEM_ready_out = ~skid_valid, taken from a flop.
- Accept: acc = EXMEM_valid_in & EXMEM_ready_out & ~flush.
- Drain: drn = EXMEM_valid_out & EXMEM_ready_in.
- Per-edge cases, with flush=0:
  - main empty, or drn:
    - main loads from skid if skid_valid (skid cleared), else from input if acc, else main_valid<=0.
    - If skid was valid and acc also holds: skid loads the input.
  - main full and ~drn:
    - If acc: skid loads the input (skid was empty by ready rule).
    - Otherwise hold.
- Latency: 1 cycle from accept to EXMEM_valid_out when empty. Steady-state throughput 1/cycle with EXMEM_ready_in held 1.
- Order preserved: skid entry always precedes any later input.
- Flush: on the edge, both valids cleared and the input is not captured. Data regs may hold stale values but ctrl_out is gated.
- Flush with simultaneous drn: MEM still consumes the head this cycle (handshake completes); nothing new loads.
- Reset asserted mid-stall: immediate clear; the in-flight entry is lost by definition.
- Data regs load only on a load event (no toggling on hold).
- No arithmetic; widths pass through unchanged.

Decomposition:
- Shared package pipe_pkg holds:
  - ctrl bit index constants CTRL_REGWRITE=3, CTRL_MEMTOREG=2, CTRL_MEMREAD=1, CTRL_MEMWRITE=0
  - CTRL_W=4
  - a packed EX/MEM payload typedef {ctrl, writereg, ALUinput2, ALUresult}, 73 bits at defaults
- One natural sub-module: pipe_skid_buf, a generic payload-width 2-entry skid buffer with flush. ex_mem_skid_reg packs and unpacks the payload around it and gates ctrl_out.

Test Plan:
- Reset then stream: ready_in=1; send ALUresult 0x10, 0x20, 0x30 on consecutive cycles -> valid_out on cycles 1–3 carrying 0x10/0x20/0x30; ready_out stays 1.
- Stall capture: head 0xA holds; ready_in=0; send 0xB -> ready_out=0 next cycle. Release ready_in -> 0xA then 0xB delivered in order, ready_out returns to 1.
- Input during full: skid full, valid_in=1 with 0xC -> not accepted. After drain, 0xC appears third, no duplication.
- Flush mid-stall: main=0x1, skid=0x2, flush=1 with valid_in 0x3 -> next cycle valid_out=0, ctrl_out RegWrite/MemRead/MemWrite=0, ready_out=1. 0x3 is never emitted.
- Flush with drain: valid_out=1, ready_in=1, flush=1 -> head consumed that cycle, valid_out=0 after.
- Async reset mid-operation: assert reset between edges with both slots full -> outputs and ready go to reset values immediately. After release, first accepted value 0x55 appears after 1 cycle.
